// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder and its neighbours
// (default address/word widths, responder state encoding).
package imem_responder_pkg;

  localparam int unsigned IMEM_N   = 5;
  localparam int unsigned IMEM_W   = 16;
  localparam int unsigned IMEM_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Saturating wait-state decrement.
  function automatic logic [3:0] cnt_dec(input logic [3:0] c);
    return (c == 4'd0) ? 4'd0 : (c - 4'd1);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Program store: 2^N x W words, synchronous write, combinational read, no reset.
module imem_array #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         wr_en,
  input  logic [N-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [N-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] r_mem [2**N];

  // Loader write port; storage is intentionally not reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch address, waits LAT cycles,
// then presents the addressed word until the requester takes it.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned N   = IMEM_N,
  parameter int unsigned W   = IMEM_W,
  parameter int unsigned LAT = IMEM_LAT
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [N-1:0] req_addr,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [N-1:0] rsp_addr,
  input  logic         wr_en,
  input  logic [N-1:0] wr_addr,
  input  logic [W-1:0] wr_data,
  output logic         busy
);

  localparam logic [3:0] LAT_C = 4'(LAT);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic         r_rsp_valid;
  logic         w_rsp_valid_nxt;
  logic [W-1:0] r_rsp_data;
  logic [W-1:0] w_rsp_data_nxt;
  logic [N-1:0] r_rsp_addr;
  logic [N-1:0] w_rsp_addr_nxt;
  logic [W-1:0] w_rd_data;

  imem_array #(
    .N(N),
    .W(W)
  ) u_array (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (r_rsp_addr),
    .rd_data (w_rd_data)
  );

  // State, wait counter and response registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_rsp_addr  <= w_rsp_addr_nxt;
    end
  end

  // Next-state logic. RESP spends its first cycle capturing the word (read
  // happens before any same-edge loader write lands), then holds until taken.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_rsp_addr_nxt  = r_rsp_addr;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_rsp_addr_nxt = req_addr;
          w_cnt_nxt      = LAT_C;
          w_state_nxt    = (LAT_C == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = cnt_dec(r_cnt);
        end
      end
      ST_RESP: begin
        if (!r_rsp_valid) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = w_rd_data;
        end else if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_cnt_nxt       = 4'd0;
        w_rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_addr  = r_rsp_addr;

endmodule

// File: tb/tb_imem_responder.sv
// Directed plus randomized checks of imem_responder against a word-array model.
module tb_imem_responder;

  localparam int LAT_A = 2;

  logic        CLK;
  logic        RST;
  logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_wr_en, a_busy;
  logic [4:0]  a_req_addr, a_rsp_addr, a_wr_addr;
  logic [15:0] a_rsp_data, a_wr_data;
  logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_wr_en, b_busy;
  logic [4:0]  b_req_addr, b_rsp_addr, b_wr_addr;
  logic [15:0] b_rsp_data, b_wr_data;

  logic [15:0] model [32];
  int n_checks = 0;
  int n_err    = 0;

  imem_responder #(.N(5), .W(16), .LAT(LAT_A)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(a_req_addr),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .rsp_addr(a_rsp_addr), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .busy(a_busy)
  );

  imem_responder #(.N(5), .W(16), .LAT(0)) dut0 (
    .CLK(CLK), .RST(RST),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .rsp_addr(b_rsp_addr), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy(b_busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives the loader port of both instances so their stores stay identical.
  task automatic set_wr(input logic en, input logic [4:0] wa, input logic [15:0] wd);
    a_wr_en = en; a_wr_addr = wa; a_wr_data = wd;
    b_wr_en = en; b_wr_addr = wa; b_wr_data = wd;
  endtask

  task automatic load(input logic [4:0] wa, input logic [15:0] wd);
    set_wr(1'b1, wa, wd);
    step();
    model[wa] = wd;
    set_wr(1'b0, 5'd0, 16'd0);
  endtask

  // Fetch on the LAT=2 instance. wr_off (1..LAT+1) places a loader write on that
  // edge after acceptance; 0 means no write. The word is sampled on edge LAT+1.
  task automatic fetch_a(input logic [4:0] addr, input int stall, input int wr_off,
                         input logic [4:0] wa, input logic [15:0] wd);
    logic [15:0] exp_data;
    exp_data = 16'd0;
    a_rsp_ready = 1'b0;
    a_req_valid = 1'b1;
    a_req_addr  = addr;
    check("a_ready_before", {31'd0, a_req_ready}, 32'd1);
    step();
    a_req_valid = 1'b0;
    check("a_busy_after_accept", {31'd0, a_busy}, 32'd1);
    for (int j = 1; j <= LAT_A + 1; j++) begin
      if (j == wr_off) set_wr(1'b1, wa, wd);
      if (j == LAT_A + 1) exp_data = model[addr];
      step();
      if (j == wr_off) begin
        model[wa] = wd;
        set_wr(1'b0, 5'd0, 16'd0);
      end
      if (j <= LAT_A) begin
        check("a_valid_early", {31'd0, a_rsp_valid}, 32'd0);
        check("a_ready_wait", {31'd0, a_req_ready}, 32'd0);
      end
    end
    check("a_valid", {31'd0, a_rsp_valid}, 32'd1);
    check("a_data", {16'd0, a_rsp_data}, {16'd0, exp_data});
    check("a_addr", {27'd0, a_rsp_addr}, {27'd0, addr});
    for (int s = 0; s < stall; s++) begin
      a_req_valid = 1'b1;
      a_req_addr  = 5'($urandom_range(31, 0));
      step();
      check("a_stall_valid", {31'd0, a_rsp_valid}, 32'd1);
      check("a_stall_data", {16'd0, a_rsp_data}, {16'd0, exp_data});
      check("a_stall_addr", {27'd0, a_rsp_addr}, {27'd0, addr});
      check("a_stall_ready", {31'd0, a_req_ready}, 32'd0);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    step();
    a_rsp_ready = 1'b0;
    check("a_valid_drop", {31'd0, a_rsp_valid}, 32'd0);
    check("a_ready_again", {31'd0, a_req_ready}, 32'd1);
    check("a_busy_clear", {31'd0, a_busy}, 32'd0);
  endtask

  // Fetch on the LAT=0 instance.
  task automatic fetch_b(input logic [4:0] addr);
    logic [15:0] exp_data;
    b_rsp_ready = 1'b0;
    b_req_valid = 1'b1;
    b_req_addr  = addr;
    check("b_ready_before", {31'd0, b_req_ready}, 32'd1);
    step();
    b_req_valid = 1'b0;
    check("b_valid_at_accept", {31'd0, b_rsp_valid}, 32'd0);
    check("b_busy", {31'd0, b_busy}, 32'd1);
    exp_data = model[addr];
    step();
    check("b_valid", {31'd0, b_rsp_valid}, 32'd1);
    check("b_data", {16'd0, b_rsp_data}, {16'd0, exp_data});
    check("b_addr", {27'd0, b_rsp_addr}, {27'd0, addr});
    b_rsp_ready = 1'b1;
    step();
    b_rsp_ready = 1'b0;
    check("b_valid_drop", {31'd0, b_rsp_valid}, 32'd0);
    check("b_ready_again", {31'd0, b_req_ready}, 32'd1);
  endtask

  initial begin
    RST = 1'b0;
    a_req_valid = 1'b0; a_req_addr = 5'd0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = 5'd0; b_rsp_ready = 1'b0;
    set_wr(1'b0, 5'd0, 16'd0);

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++) begin
      a_req_valid = 1'($urandom); a_req_addr = 5'($urandom); a_rsp_ready = 1'($urandom);
      b_req_valid = 1'($urandom); b_req_addr = 5'($urandom); b_rsp_ready = 1'($urandom);
      set_wr(1'($urandom), 5'($urandom), 16'($urandom));
      step();
      check("rst_valid", {31'd0, a_rsp_valid}, 32'd0);
      check("rst_ready", {31'd0, a_req_ready}, 32'd1);
      check("rst_busy", {31'd0, a_busy}, 32'd0);
      check("rst_data", {16'd0, a_rsp_data}, 32'd0);
      check("rst_b_valid", {31'd0, b_rsp_valid}, 32'd0);
    end
    a_req_valid = 1'b0; a_rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_rsp_ready = 1'b0;
    set_wr(1'b0, 5'd0, 16'd0);
    RST = 1'b1;
    step();

    for (int i = 0; i < 32; i++) load(5'(i), 16'($urandom));

    // Basic fetch and backpressure.
    load(5'd3, 16'hBEEF);
    fetch_a(5'd3, 0, 0, 5'd0, 16'd0);
    check("basic_beef", {16'd0, a_rsp_data}, 32'h0000BEEF);
    fetch_a(5'd3, 4, 0, 5'd0, 16'd0);

    // Zero-latency instance.
    fetch_b(5'd7);

    // Write collision on the capture edge versus one edge earlier.
    load(5'd5, 16'h1234);
    fetch_a(5'd5, 0, LAT_A + 1, 5'd5, 16'h5678);
    check("coll_same_edge", {16'd0, a_rsp_data}, 32'h00001234);
    load(5'd5, 16'h1234);
    fetch_a(5'd5, 0, LAT_A, 5'd5, 16'h5678);
    check("coll_early_edge", {16'd0, a_rsp_data}, 32'h00005678);

    // Reset mid-WAIT.
    a_req_valid = 1'b1; a_req_addr = 5'd9;
    step();
    a_req_valid = 1'b0;
    step();
    check("midwait_busy", {31'd0, a_busy}, 32'd1);
    #2 RST = 1'b0;
    #1;
    check("async_valid", {31'd0, a_rsp_valid}, 32'd0);
    check("async_ready", {31'd0, a_req_ready}, 32'd1);
    check("async_busy", {31'd0, a_busy}, 32'd0);
    check("async_data", {16'd0, a_rsp_data}, 32'd0);
    step();
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("no_stale_valid", {31'd0, a_rsp_valid}, 32'd0);
      check("no_stale_ready", {31'd0, a_req_ready}, 32'd1);
    end
    fetch_a(5'd31, 1, 0, 5'd0, 16'd0);

    // Randomized fetches with optional loader traffic during the wait.
    for (int i = 0; i < 24; i++) begin
      logic [4:0] ra, wa;
      int off;
      ra  = 5'($urandom_range(31, 0));
      wa  = ($urandom_range(1, 0) == 1) ? ra : 5'($urandom_range(31, 0));
      off = $urandom_range(LAT_A + 1, 0);
      fetch_a(ra, $urandom_range(3, 0), off, wa, 16'($urandom));
      if ($urandom_range(3, 0) == 0) load(5'($urandom_range(31, 0)), 16'($urandom));
    end
    for (int i = 0; i < 8; i++) fetch_b(5'($urandom_range(31, 0)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
